// File: rtl/gpu_bus_defs.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_bus_defs (package)
//  Purpose  : Shared opcodes, byte counts, bus state encoding and command
//             layout for the GPU 8-bit command bus (encoder and decoder).
//  Revision : 1.0  initial release
// ============================================================================
package gpu_bus_defs;

    localparam logic [7:0] OP_SET_MODE  = 8'h01;
    localparam logic [7:0] OP_SET_PIXEL = 8'h02;

    localparam int unsigned BYTES_MODE  = 2;
    localparam int unsigned BYTES_PIXEL = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRE     = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic        op;     // 0 = set mode, 1 = set pixel
        logic [7:0]  mode;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] color;  // RGB444 {R,G,B}
    } gpu_cmd_t;

    // Byte idx of the serialized stream, MSB-first.
    function automatic logic [7:0] cmd_byte(input gpu_cmd_t cmd, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (!cmd.op) begin
            b = (idx == 3'd0) ? OP_SET_MODE : cmd.mode;
        end else begin
            case (idx)
                3'd0:    b = OP_SET_PIXEL;
                3'd1:    b = {6'b0, cmd.x[9:8]};
                3'd2:    b = cmd.x[7:0];
                3'd3:    b = {6'b0, cmd.y[9:8]};
                3'd4:    b = cmd.y[7:0];
                3'd5:    b = {4'b0, cmd.color[11:8]};
                3'd6:    b = cmd.color[7:0];
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    function automatic logic [2:0] last_idx(input logic op);
        return op ? 3'(BYTES_PIXEL - 1) : 3'(BYTES_MODE - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_bus_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_bus_strobe
//  Purpose  : Per-byte four-phase en/ack engine. Runs the IDLE/PRE/STROBE/
//             RELEASE sequence, loads the bus byte on STROBE entry and
//             reports byte advance, command done and timeout abort.
//  Options  : GPU_BUS_ENC_TIMEOUT_EN enables the ack-wait timeout counter.
//  Revision : 1.0  initial release
// ============================================================================
module gpu_bus_strobe
    import gpu_bus_defs::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,   // command accepted this cycle
    input  logic       ack_i,
    input  logic       last_i,    // byte in flight is the final one
    input  logic [7:0] byte_i,    // byte to load on STROBE entry
    output logic       en_o,
    output logic [7:0] data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       adv_o      // current byte finished, move index on
);

    // A timeout below 2 cannot leave room for a single ack wait.
    if (ACK_TIMEOUT < 2) begin : g_timeout_range
        $error("gpu_bus_strobe: ACK_TIMEOUT must be at least 2");
    end

    bus_state_e state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       en_q;
    logic       done_q, done_d;

`ifdef GPU_BUS_ENC_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q, err_d;
    logic             timeout;

    // Abort decided one cycle early so en drops exactly ACK_TIMEOUT cycles after entry.
    assign timeout = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`endif

    // Next-state, byte load and completion decode.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        adv_o   = 1'b0;
`ifdef GPU_BUS_ENC_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE:    if (start_i) state_d = ack_i ? ST_PRE : ST_STROBE;
            ST_PRE:     if (!ack_i)  state_d = ST_STROBE;
            ST_STROBE:  if (ack_i)   state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!ack_i) begin
                    adv_o = 1'b1;
                    if (last_i) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_STROBE;
                    end
                end
            end
            default:    state_d = ST_IDLE;
        endcase
`ifdef GPU_BUS_ENC_TIMEOUT_EN
        // A real handshake step in the same cycle wins over the abort.
        if ((state_q != ST_IDLE) && (state_d == state_q) && timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
`endif
        data_d = data_q;
        if ((state_d == ST_STROBE) && (state_q != ST_STROBE)) begin
            data_d = byte_i;
        end else if (state_d == ST_IDLE) begin
            data_d = 8'h00;
        end
    end

    // State and registered bus outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= (state_d == ST_STROBE);
            done_q  <= done_d;
        end
    end

`ifdef GPU_BUS_ENC_TIMEOUT_EN
    // Ack-wait counter: restarts on each state entry, runs while waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q != ST_IDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign en_o   = en_q;
    assign data_o = data_q;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/gpu_bus_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_bus_encoder
//  Purpose  : Host-side master for the GPU 8-bit command bus. Latches one
//             set-mode / set-pixel command and serializes it MSB-first as
//             opcode + operand bytes over a four-phase en/ack handshake.
//  Options  : GPU_BUS_ENC_TIMEOUT_EN enables ack timeout abort (o_err).
//  Revision : 1.0  initial release
// ============================================================================
module gpu_bus_encoder
    import gpu_bus_defs::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_op,
    input  logic [7:0]  i_mode,
    input  logic [9:0]  i_pixel_x,
    input  logic [9:0]  i_pixel_y,
    input  logic [11:0] i_color,
    output logic        o_we,
    output logic        o_en,
    output logic [7:0]  o_data,
    input  logic        i_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    gpu_cmd_t   cmd_q;
    gpu_cmd_t   cmd_in;
    logic [2:0] idx_q;
    logic [2:0] idx_sel;
    logic       accept;
    logic       busy;
    logic       adv;
    logic       last;
    logic [7:0] next_byte;

    assign cmd_in = '{op: i_cmd_op, mode: i_mode, x: i_pixel_x, y: i_pixel_y, color: i_color};
    assign accept = i_cmd_valid && !busy;

    // Byte loaded on STROBE entry: opcode straight from the inputs on accept,
    // otherwise the latched command at the index being moved to.
    assign idx_sel   = adv ? (idx_q + 3'd1) : idx_q;
    assign next_byte = accept ? cmd_byte(cmd_in, 3'd0) : cmd_byte(cmd_q, idx_sel);
    assign last      = (idx_q == last_idx(cmd_q.op));

    // Command latch and byte index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q <= '0;
            idx_q <= 3'd0;
        end else if (accept) begin
            cmd_q <= cmd_in;
            idx_q <= 3'd0;
        end else if (adv) begin
            idx_q <= idx_q + 3'd1;
        end
    end

    gpu_bus_strobe #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_strobe (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .start_i (accept),
        .ack_i   (i_ack),
        .last_i  (last),
        .byte_i  (next_byte),
        .en_o    (o_en),
        .data_o  (o_data),
        .busy_o  (busy),
        .done_o  (o_done),
        .err_o   (o_err),
        .adv_o   (adv)
    );

    assign o_we        = o_en;
    assign o_busy      = busy;
    assign o_cmd_ready = !busy;

endmodule
`default_nettype wire

// File: tb/tb_gpu_bus_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_bus_encoder
//  Purpose  : Self-checking bench for gpu_bus_encoder with a registered
//             ack responder and a byte/done scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpu_bus_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [7:0]  mode;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] color;
    logic        we;
    logic        en;
    logic [7:0]  data;
    logic        ack;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0] byte_q[$];
    int         done_q[$];

    bit resp_force_hi = 1'b0;
    bit resp_silent   = 1'b0;
    bit err_expect    = 1'b0;
    logic en_prev     = 1'b0;
    int   mon_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpu_bus_encoder #(
        .ACK_TIMEOUT (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_mode      (mode),
        .i_pixel_x   (px),
        .i_pixel_y   (py),
        .i_color     (color),
        .o_we        (we),
        .o_en        (en),
        .o_data      (data),
        .i_ack       (ack),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    // Decoder model: ack follows en one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack <= 1'b0;
        else        ack <= resp_force_hi | (!resp_silent & en);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: compare each strobed byte and each done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (en && !en_prev) begin
                check("we_on_strobe", {31'd0, we}, 32'd1);
                if (byte_q.size() == 0) check("byte_unexpected", 32'd1, 32'd0);
                else                    check("byte", {24'd0, data}, {24'd0, byte_q.pop_front()});
            end
            if (!en && en_prev) check("we_on_release", {31'd0, we}, 32'd0);
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", cyc, mon_d);
                end
            end
            if (err && !err_expect) check("err_unexpected", 32'd1, 32'd0);
        end
        en_prev = en;
    end

    function automatic void push_bytes(input logic op, input logic [7:0] m, input logic [9:0] x,
                                       input logic [9:0] y, input logic [11:0] c);
        if (!op) begin
            byte_q.push_back(8'h01);
            byte_q.push_back(m);
        end else begin
            byte_q.push_back(8'h02);
            byte_q.push_back({6'b0, x[9:8]});
            byte_q.push_back(x[7:0]);
            byte_q.push_back({6'b0, y[9:8]});
            byte_q.push_back(y[7:0]);
            byte_q.push_back({4'b0, c[11:8]});
            byte_q.push_back(c[7:0]);
        end
    endfunction

    // Drive one command; acc is the cycle whose edge accepts it.
    // With the one-cycle responder each byte costs 4 cycles, so done lands
    // at acc + 4*N (8 for mode, 28 for pixel).
    task automatic send(input logic op, input logic [7:0] m, input logic [9:0] x, input logic [9:0] y,
                        input logic [11:0] c, input bit push_done, output int acc);
        int k;
        @(negedge clk);
        cmd_op = op; mode = m; px = x; py = y; color = c; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("ready_wait_expired", 32'd0, 32'd1);
        acc = cyc + 1;
        push_bytes(op, m, x, y, c);
        if (push_done) done_q.push_back(acc + (op ? 28 : 8));
        @(negedge clk);
        cmd_valid = 1'b0;
        // Scramble operands to prove they were latched.
        cmd_op = 1'($urandom); mode = 8'($urandom); px = 10'($urandom);
        py = 10'($urandom); color = 12'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((byte_q.size() != 0 || done_q.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("idle_wait_expired", 32'd0, 32'd1);
        @(negedge clk);
        check("idle_data", {24'd0, data}, 32'd0);
        check("idle_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int p1, p2, r, rises, k, ndone;
        logic p;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; mode = 8'h00;
        px = '0; py = '0; color = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_we",    {31'd0, we},        32'd0);
        check("rst_en",    {31'd0, en},        32'd0);
        check("rst_data",  {24'd0, data},      32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_done",  {31'd0, done},      32'd0);
        check("rst_err",   {31'd0, err},       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode command
        send(1'b0, 8'h5A, 10'h0, 10'h0, 12'h0, 1'b1, p1);
        wait_idle();

        // Pixel command
        send(1'b1, 8'h00, 10'h2AB, 10'h1CD, 12'hF0E, 1'b1, p1);
        wait_idle();

        // Stale ack held high at accept
        @(negedge clk);
        resp_force_hi = 1'b1;
        send(1'b0, 8'h00, 10'h0, 10'h0, 12'h0, 1'b0, p1);
        repeat (6) begin
            @(negedge clk);
            check("pre_en",   {31'd0, en},   32'd0);
            check("pre_busy", {31'd0, busy}, 32'd1);
        end
        r = cyc;
        resp_force_hi = 1'b0;
        // ack drops at r+1, PRE leaves at r+2, then a normal 8-cycle stream.
        done_q.push_back(r + 10);
        wait_idle();

        // Reset during the STROBE of byte 3 of a pixel command
        send(1'b1, 8'h00, 10'h3FF, 10'h000, 12'hABC, 1'b0, p1);
        rises = (en ? 1 : 0);
        p = en;
        k = 0;
        while (rises < 4 && k < 100) begin
            @(negedge clk);
            if (en && !p) rises++;
            p = en;
            k++;
        end
        if (k >= 100) check("byte3_wait_expired", 32'd0, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_en",   {31'd0, en},   32'd0);
        check("mid_rst_data", {24'd0, data}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        byte_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("post_rst_no_done", ndone, 32'd0);

        // Back-to-back with valid held high
        @(negedge clk);
        cmd_op = 1'b0; mode = 8'h33; cmd_valid = 1'b1;
        p1 = cyc + 1;
        push_bytes(1'b0, 8'h33, 10'h0, 10'h0, 12'h0);
        done_q.push_back(p1 + 8);
        @(negedge clk);
        cmd_op = 1'b1; px = 10'h155; py = 10'h2AA; color = 12'h123;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("b2b_wait_expired", 32'd0, 32'd1);
        check("b2b_accept_cycle", cyc, p1 + 8);
        check("b2b_done_same_cycle", {31'd0, done}, 32'd1);
        p2 = cyc + 1;
        push_bytes(1'b1, 8'h00, 10'h155, 10'h2AA, 12'h123);
        done_q.push_back(p2 + 28);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_en", {31'd0, en}, 32'd1);
        wait_idle();

`ifdef GPU_BUS_ENC_TIMEOUT_EN
        // No ack ever: abort 16 cycles after STROBE entry
        resp_silent = 1'b1;
        err_expect  = 1'b1;
        send(1'b0, 8'h77, 10'h0, 10'h0, 12'h0, 1'b0, p1);
        repeat (15) @(negedge clk);
        check("to_en_held",   {31'd0, en},  32'd1);
        check("to_err_early", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("to_en_drop",   {31'd0, en},   32'd0);
        check("to_err_pulse", {31'd0, err},  32'd1);
        check("to_idle",      {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("to_err_once",  {31'd0, err},       32'd0);
        check("to_ready",     {31'd0, cmd_ready}, 32'd1);
        byte_q.delete();
        resp_silent = 1'b0;
        err_expect  = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("bytes_drained", byte_q.size(), 32'd0);
        check("dones_drained", done_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/gpu_bus_encoder.md
# gpu_bus_encoder

Host-side master for the GPU's 8-bit command bus. It takes one parallel command per handshake, either set-mode or set-pixel, and serializes it MSB-first into opcode and operand bytes. Each byte is driven onto `o_data` with a four-phase `o_en`/`i_ack` handshake. It sits in the host/test FPGA and connects pin-for-pin to the GPU's instruction decoder inputs (we, en, data, ack).

## Interface
- `ACK_TIMEOUT`, 255: cycles allowed in any ack-wait state before abort; used only with `GPU_BUS_ENC_TIMEOUT_EN`.
- `i_clk` in 1: sole clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_cmd_valid` in 1: command present.
- `o_cmd_ready` out 1: encoder idle; accepts a command this cycle.
- `i_cmd_op` in 1: 0 = set mode, 1 = set pixel.
- `i_mode` in 8: mode operand.
- `i_pixel_x` in 10, `i_pixel_y` in 10: pixel coordinates.
- `i_color` in 12: RGB444 color, {R,G,B}.
- `o_we` out 1: write strobe qualifier, 1 whenever `o_en`=1.
- `o_en` out 1: byte strobe.
- `o_data` out 8: bus byte.
- `i_ack` in 1: decoder acknowledge, already synchronous to `i_clk`.
- `o_busy` out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse when a command completes.
- `o_err` out 1: one-cycle pulse on timeout abort; tied 0 without the macro.

## Operation
- Accept when `i_cmd_valid && o_cmd_ready`. All operands are latched; later input changes are ignored.
- Byte streams:
  - Mode: 0x01, mode.
  - Pixel: 0x02, {6'b0,x[9:8]}, x[7:0], {6'b0,y[9:8]}, y[7:0], {4'b0,c[11:8]}, c[7:0].
- States:
  - IDLE: on accept, go to PRE if `i_ack`=1, else STROBE.
  - PRE: `o_en`=0; wait for `i_ack`=0, which clears a stale ack, then go to STROBE.
  - STROBE: `o_en`=`o_we`=1, `o_data`=current byte. When `i_ack`=1 is sampled, go to RELEASE.
  - RELEASE: `o_en`=`o_we`=0, `o_data` held. When `i_ack`=0 is sampled, advance the byte index. If bytes remain, go to STROBE; if it was the last byte, go to IDLE and pulse `o_done`.
- Byte counter is 3 bits, reset to 0 on each accept. Last index is 1 for mode and 6 for pixel.
- `o_data` is 0x00 in IDLE. It changes only on the STROBE entry cycle.
- `i_cmd_valid` while busy: ignored; the command is held off by `o_cmd_ready`=0.
- Reset at any time, including mid-byte: all outputs drop immediately, the command is discarded, and the encoder returns to IDLE.
- Reset values: `o_cmd_ready`=1, `o_we`=0, `o_en`=0, `o_data`=0x00, `o_busy`=0, `o_done`=0, `o_err`=0.

## Timing
- All outputs are registered and derived from the state/data registers.
- If accepted at cycle 0 with `i_ack`=0, `o_en` rises at cycle 1.
- If `i_ack`=1 is first sampled at cycle t, `o_en` falls at t+1.
- If `i_ack`=0 is then sampled at cycle u, either the next byte's `o_en` rises at u+1, or `o_done`=1 and `o_cmd_ready`=1 at u+1.
- With a decoder that acks and releases one cycle after each edge, each byte takes 4 cycles. A mode command then takes 8 cycles and a pixel command 28 cycles, measured from accept to the `o_done` cycle inclusive.
- Back-to-back commands: a new accept is allowed in the same cycle `o_done` is high.

## Configuration
- `GPU_BUS_ENC_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on every state entry and increments each cycle in PRE, STROBE or RELEASE.
  - When it reaches `ACK_TIMEOUT`, the encoder forces `o_en`=0, pulses `o_err` for 1 cycle, drops the remaining bytes and enters IDLE. `o_done` does not pulse.
- Undefined: the encoder waits for ack indefinitely, `o_err` is constant 0, and there is no counter.

## Structure
- Shared package `gpu_bus_defs`, also used by the decoder:
  - `OP_SET_MODE`=8'h01, `OP_SET_PIXEL`=8'h02.
  - Byte counts 2 and 7.
  - State encoding IDLE/PRE/STROBE/RELEASE.
- One natural sub-module, `gpu_bus_strobe`: the per-byte four-phase engine, including the timeout counter. It takes a byte and a start signal and returns done/err. The top level holds the command latch, byte mux and sequencing.

## Test plan
- Mode 0x5A, responder acks 1 cycle after `o_en` rises and releases 1 cycle after it falls -> bytes 0x01, 0x5A; `o_done` pulses once 8 cycles after accept.
- Pixel x=0x2AB, y=0x1CD, c=0xF0E -> bytes 0x02, 0x02, 0xAB, 0x01, 0xCD, 0x0F, 0x0E in order; `o_we`=`o_en` on every strobe.
- `i_ack` stuck at 1 when mode 0x00 is accepted -> `o_en` stays 0 until ack falls, then the normal 2-byte sequence.
- `i_rst_n` pulsed low while byte 3 of a pixel command is in STROBE -> `o_en`, `o_data` and `o_busy` are 0 immediately; after release `o_cmd_ready`=1 and no `o_done` pulse.
- Timeout (macro on, `ACK_TIMEOUT`=16), no ack ever -> `o_en` falls and `o_err` pulses 16 cycles after STROBE entry; then IDLE.
- Valid held high through two back-to-back commands -> second accepted in the first's `o_done` cycle; no byte gap beyond 1 cycle.
